serial_tx_fifo: RTL and testbench
=================================

SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 5, meaning FIFO holds 2**DEPTH bytes.
REQ-002 Parameter OVS, default 16, meaning CLK_RX cycles per serial bit (min 2).
REQ-003 Port CLK_RX  input  1  serial-side clock, OVS x baud rate.
REQ-004 Port RST  input  1  reset, synchronous, active-low; sampled in both clock domains.
REQ-005 Port CLK_WR  input  1  producer-side write clock, asynchronous to CLK_RX.
REQ-006 Port WR_EN  input  1  write strobe, CLK_WR domain.
REQ-007 Port DATA  input  8  byte to enqueue.
REQ-008 Port FULL  output  1  FIFO full, registered in CLK_WR domain.
REQ-009 Port TX  output  1  serial line, idle high, registered in CLK_RX domain.
REQ-010 Port BUSY  output  1  frame in progress or FIFO non-empty, registered in CLK_RX domain.

Function
REQ-011 On a CLK_WR edge with WR_EN=1 and FULL=0, DATA SHALL be stored at the write pointer and the pointer incremented; WR_EN while FULL=1 SHALL be ignored without corrupting stored data.
REQ-012 Pointers SHALL be DEPTH+1 bits, Gray-coded for crossing, each synchronised through two flops into the opposite domain; all 2**DEPTH entries SHALL be usable.
REQ-013 FULL SHALL assert on the CLK_WR edge that stores the last free entry and deassert no later than 3 CLK_WR edges after the read pointer frees an entry.
REQ-014 Empty SHALL be computed in CLK_RX domain as synced write pointer equal to read pointer; a byte written SHALL be seen non-empty within 3 CLK_RX edges.
REQ-015 Transmit state machine states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: TX=1; on non-empty, pop the head byte into the shift register, increment read pointer, go to START.
REQ-017 START: TX=0 for OVS cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each held OVS cycles, then PARITY or STOP.
REQ-019 STOP: TX=1 for OVS cycles; at its last cycle, if non-empty pop and go directly to START (no idle gap), else go to IDLE.
REQ-020 A bit-tick counter of ceil(log2(OVS)) bits and a 3-bit bit index SHALL wrap to 0 at each bit/byte boundary.
REQ-021 TX SHALL change only on bit boundaries; no glitch between bits.
REQ-022 BUSY SHALL be 0 only when state is IDLE and FIFO empty.
REQ-023 Pointer wrap past 2**DEPTH SHALL preserve byte order; write and pop in the same instant SHALL both take effect.

Reset
REQ-024 RST=0 in CLK_RX domain SHALL force IDLE, TX=1, BUSY=0, read pointer 0, counters 0, on the next CLK_RX edge, aborting any frame mid-bit.
REQ-025 RST=0 in CLK_WR domain SHALL force write pointer 0, FULL=0; FIFO contents are discarded, storage array is not cleared.
REQ-026 Synchroniser flops SHALL be cleared by RST in their own domain.

Configuration
REQ-027 Macro SERIAL_TX_PARITY_EN defined: PARITY state inserted after DATA, TX = XOR of the 8 data bits (even parity) for OVS cycles; frame 11 bits.
REQ-028 Macro undefined: no PARITY state, no parity logic; frame 10 bits (8N1).

Structure
REQ-029 Shared package SHALL hold the state encoding constants and the frame-length constants (10/11 bits).
REQ-030 One sub-module SERIAL_TX (shift engine, state machine, TX/BUSY) SHALL be instantiated; FIFO storage, pointers and synchronisers stay in the top.

Verification
REQ-031 Reset: hold RST=0 4 cycles each clock -> TX=1, BUSY=0, FULL=0.
REQ-032 OVS=16, write 0xA5 -> TX: 0 x16, then 1,0,1,0,0,1,0,1 each x16, stop 1 x16; 160 cycles (with macro parity 0 inserted, 176).
REQ-033 DEPTH=5, CLK_WR 50 MHz, CLK_RX 1.8432 MHz, write 33 bytes 0x00..0x20 back-to-back -> FULL after 32nd, 0x20 dropped, 0x00..0x1F sent in order.
REQ-034 Write 0x00,0xFF together -> second start bit immediately follows first stop bit, zero idle cycles; BUSY stays 1 until final stop bit ends.
REQ-035 RST=0 during data bit 3 of 0x3C -> TX=1 next edge, BUSY=0, no further frames after RST=1 until new write.
REQ-036 Macro defined, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx_fifo_pkg.sv
// Shared state encoding and frame-length constants for serial_tx_fifo.
// SERIAL_TX_PARITY_EN selects the 11-bit even-parity frame, otherwise 8N1.
package serial_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage

// File: rtl/serial_tx_fifo_tx.sv
// Serial shift engine: start, 8 data bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), stop; back-to-back frames when the FIFO has data.
module serial_tx_fifo_tx
  import serial_tx_fifo_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       empty_i,
  input  logic [7:0] head_i,
  output logic       pop_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(OVS);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVS - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] tick_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  assign bit_end = (tick_q == TICK_LAST);
  // Pop in IDLE, or on the last stop-bit cycle so the next start bit follows with no gap.
  assign pop_o   = !empty_i && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      tick_q <= bit_end ? '0 : tick_q + CNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          tick_q <= '0;
          if (!empty_i) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_START: if (bit_end) begin
          state_q <= ST_DATA;
          idx_q   <= '0;
          tx_q    <= shift_q[0];
        end
        ST_DATA: if (bit_end) begin
          shift_q <= shift_q >> 1;
          idx_q   <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_q <= ST_PARITY;
            tx_q    <= par_q;
`else
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            tx_q <= shift_q[1];
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: if (bit_end) begin
          state_q <= ST_STOP;
          tx_q    <= 1'b1;
        end
`endif
        ST_STOP: if (bit_end) begin
          if (!empty_i) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (pop_o) begin
        shift_q <= head_i;
`ifdef SERIAL_TX_PARITY_EN
        par_q   <= ^head_i;
`endif
      end
    end
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// Dual-clock byte FIFO (Gray pointers, 2-flop synchronisers) feeding a UART
// transmitter. SERIAL_TX_PARITY_EN adds an even parity bit to each frame.
module serial_tx_fifo
  import serial_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int OVS   = 16
) (
  input  logic       CLK_RX,
  input  logic       RST,
  input  logic       CLK_WR,
  input  logic       WR_EN,
  input  logic [7:0] DATA,
  output logic       FULL,
  output logic       TX,
  output logic       BUSY
);

  localparam int PW = DEPTH + 1;

  logic [7:0]    mem_q [2**DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0] rgray_s1_q, rgray_s2_q;
  logic          full_q, full_d, wr_fire;

  logic [PW-1:0] rbin_q, rbin_d, rgray_q;
  logic [PW-1:0] wgray_s1_q, wgray_s2_q;
  logic          empty, pop;
  logic [7:0]    head;

  assign wr_fire = WR_EN && !full_q;
  assign wbin_d  = wbin_q + PW'(wr_fire);
  assign wgray_d = wbin_d ^ (wbin_d >> 1);
  // Full when the next write pointer equals the read pointer with the top two Gray bits inverted.
  assign full_d  = (wgray_d == {~rgray_s2_q[PW-1 -: 2], rgray_s2_q[PW-3:0]});
  assign FULL    = full_q;

  always_ff @(posedge CLK_WR) begin
    if (!RST) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
    end
  end

  always_ff @(posedge CLK_WR) begin
    if (wr_fire) mem_q[wbin_q[DEPTH-1:0]] <= DATA;
  end

  assign empty  = (wgray_s2_q == rgray_q);
  assign head   = mem_q[rbin_q[DEPTH-1:0]];
  assign rbin_d = rbin_q + PW'(pop);

  always_ff @(posedge CLK_RX) begin
    if (!RST) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rbin_d ^ (rbin_d >> 1);
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
    end
  end

  serial_tx_fifo_tx #(.OVS(OVS)) u_tx (
    .clk_i   (CLK_RX),
    .rst_ni  (RST),
    .empty_i (empty),
    .head_i  (head),
    .pop_o   (pop),
    .tx_o    (TX),
    .busy_o  (BUSY)
  );

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo (DEPTH=5, OVS=16); honours SERIAL_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_serial_tx_fifo;

  localparam int DEPTH = 5;
  localparam int OVS   = 16;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif

  logic       CLK_RX = 1'b0;
  logic       CLK_WR = 1'b0;
  logic       RST    = 1'b0;
  logic       WR_EN  = 1'b0;
  logic [7:0] DATA   = 8'h00;
  logic       FULL, TX, BUSY;
  bit         wr_run = 1'b1;
  int         checks = 0;
  int         errors = 0;

  serial_tx_fifo #(.DEPTH(DEPTH), .OVS(OVS)) dut (
    .CLK_RX (CLK_RX),
    .RST    (RST),
    .CLK_WR (CLK_WR),
    .WR_EN  (WR_EN),
    .DATA   (DATA),
    .FULL   (FULL),
    .TX     (TX),
    .BUSY   (BUSY)
  );

  // 1.8432 MHz serial clock; 50 MHz write clock, parked low while the producer is idle.
  always #271.267 CLK_RX = ~CLK_RX;
  always #10 CLK_WR = wr_run ? ~CLK_WR : 1'b0;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FR == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wr_start();
    wr_run = 1'b1;
    repeat (2) @(negedge CLK_WR);
  endtask

  task automatic wr_put(input logic [7:0] b);
    WR_EN = 1'b1;
    DATA  = b;
    @(negedge CLK_WR);
  endtask

  task automatic wr_stop();
    WR_EN = 1'b0;
    repeat (2) @(negedge CLK_WR);
    wr_run = 1'b0;
  endtask

  task automatic wait_start(input string nm, input int lim);
    int n = 0;
    while (TX !== 1'b0 && n < lim) begin
      @(negedge CLK_RX);
      n++;
    end
    checks++;
    if (TX !== 1'b0) begin
      errors++;
      $display("FAIL %s start: TX=%b after %0d cycles, required 0", nm, TX, n);
    end
  endtask

  // Samples one whole frame starting on its first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input string nm);
    int   bad   = 0;
    int   first = -1;
    logic got_tx = 1'b0, got_busy = 1'b0, want = 1'b0;
    for (int i = 0; i < FR * OVS; i++) begin
      if (TX !== exp_bit(b, i / OVS) || BUSY !== 1'b1) begin
        if (bad == 0) begin
          first = i; got_tx = TX; got_busy = BUSY; want = exp_bit(b, i / OVS);
        end
        bad++;
      end
      @(negedge CLK_RX);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s frame 0x%02h: %0d bad samples, first at cycle %0d TX=%b BUSY=%b, required TX=%b BUSY=1",
               nm, b, bad, first, got_tx, got_busy, want);
    end
  endtask

  task automatic check_idle(input string nm, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
      @(negedge CLK_RX);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: %0d of %0d cycles not TX=1 BUSY=0, required 0", nm, bad, cycles);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    wr_run = 1'b1;
    repeat (4) @(negedge CLK_RX);
    checks++; if (TX !== 1'b1)   begin errors++; $display("FAIL reset TX: got %b, required 1", TX); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset BUSY: got %b, required 0", BUSY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset FULL: got %b, required 0", FULL); end
    RST = 1'b1;
    wr_run = 1'b0;
    repeat (2) @(negedge CLK_RX);
  endtask

  task automatic test_single();
    wr_start(); wr_put(8'hA5); wr_stop();
    wait_start("single", 10);
    check_frame(8'hA5, "single");
    check_idle("single", 2 * OVS);
  endtask

  task automatic test_back_to_back();
    wr_start(); wr_put(8'h00); wr_put(8'hFF); wr_stop();
    wait_start("b2b", 10);
    check_frame(8'h00, "b2b_first");
    check_frame(8'hFF, "b2b_second");
    check_idle("b2b", 2 * OVS);
  endtask

  task automatic test_full();
    wr_start();
    for (int i = 0; i < 33; i++) begin
      if (i == 31) begin
        checks++;
        if (FULL !== 1'b0) begin errors++; $display("FAIL full_after31: FULL=%b, required 0", FULL); end
      end
      if (i == 32) begin
        checks++;
        if (FULL !== 1'b1) begin errors++; $display("FAIL full_after32: FULL=%b, required 1", FULL); end
      end
      wr_put(8'(i));
    end
    wr_stop();
    wait_start("full", 10);
    for (int i = 0; i < 32; i++) check_frame(8'(i), "full_seq");
    wr_run = 1'b1;
    repeat (4) @(negedge CLK_WR);
    checks++;
    if (FULL !== 1'b0) begin errors++; $display("FAIL full_release: FULL=%b, required 0", FULL); end
    wr_run = 1'b0;
    @(negedge CLK_RX);
    check_idle("full_drop", 3 * OVS);
  endtask

  task automatic test_reset_midframe();
    wr_start(); wr_put(8'h3C); wr_stop();
    wait_start("midrst", 10);
    repeat (OVS + 3 * OVS + OVS / 2) @(negedge CLK_RX);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL midrst_bit3: TX=%b, required 1", TX); end
    wr_run = 1'b1;
    RST = 1'b0;
    @(negedge CLK_RX);
    checks++; if (TX !== 1'b1)   begin errors++; $display("FAIL midrst TX: got %b, required 1", TX); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst BUSY: got %b, required 0", BUSY); end
    @(negedge CLK_RX);
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL midrst FULL: got %b, required 0", FULL); end
    RST = 1'b1;
    wr_run = 1'b0;
    check_idle("midrst", 2 * FR * OVS);
  endtask

  task automatic test_after_reset();
    wr_start(); wr_put(8'hC3); wr_stop();
    wait_start("postrst", 10);
    check_frame(8'hC3, "postrst");
    check_idle("postrst", OVS);
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    wr_start(); wr_put(8'h07); wr_stop();
    wait_start("par07", 10);
    repeat (9 * OVS + OVS / 2) @(negedge CLK_RX);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL parity07: TX=%b, required 1", TX); end
    repeat (FR * OVS - 9 * OVS - OVS / 2) @(negedge CLK_RX);
    check_idle("par07", OVS);
    wr_start(); wr_put(8'h03); wr_stop();
    wait_start("par03", 10);
    repeat (9 * OVS + OVS / 2) @(negedge CLK_RX);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL parity03: TX=%b, required 0", TX); end
    repeat (FR * OVS - 9 * OVS - OVS / 2) @(negedge CLK_RX);
    check_idle("par03", OVS);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_midframe();
    test_after_reset();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
